// File: rtl/bit_scan_pkg.sv
// Shared definitions for the bit-scan scheduler.
//   state_t                - two-state scheduler FSM encoding
//   bs_idx_width(dw)       - index width for a request mask of dw bits
//   BS_DEFAULT_DATA_WIDTH  - default request-mask width
//   BS_DEFAULT_IDX_W       - index width at the default mask width
package bit_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int BS_DEFAULT_DATA_WIDTH = 32;

    // Index width as a function of the mask width; used as a constant function.
    function automatic int bs_idx_width(input int dw);
        return $clog2(dw);
    endfunction

    localparam int BS_DEFAULT_IDX_W = bs_idx_width(BS_DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/trailing_zeros.sv
// Trailing-zero counter.
//   DATA_WIDTH  - input width (power of two, >= 2)
//   din         - input vector
//   dout        - number of trailing zeros in din; equals DATA_WIDTH when din is 0
module trailing_zeros #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]         din,
    output logic [$clog2(DATA_WIDTH):0]   dout
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    // Scan from MSB down so the lowest set bit is the final assignment.
    always_comb begin
        dout = CW'(DATA_WIDTH);
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (din[i]) begin
                dout = CW'(i);
            end else begin
                dout = dout;
            end
        end
    end

endmodule

// File: rtl/bit_scan_scheduler.sv
// Bit-scan scheduler: accepts a request mask and emits the index of each set
// bit, lowest first, one per out_valid/out_ready handshake.
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - mask handshake (ready only in IDLE)
//   in_mask             - set of pending requester bits
//   out_valid/out_ready - index handshake (valid throughout SCAN)
//   out_idx             - index of the lowest remaining set bit
//   out_last            - out_idx is the final index for this mask
//   out_seq             - indices already emitted for this mask
//   done                - one-cycle pulse after a mask is fully serviced
module bit_scan_scheduler
    import bit_scan_pkg::*;
#(
    parameter int DATA_WIDTH = BS_DEFAULT_DATA_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_WIDTH-1:0]                 in_mask,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [bs_idx_width(DATA_WIDTH)-1:0]   out_idx,
    output logic                                  out_last,
    output logic [bs_idx_width(DATA_WIDTH):0]     out_seq,
    output logic                                  done
);

    localparam int IDX_W = bs_idx_width(DATA_WIDTH);
    localparam int SEQ_W = IDX_W + 1;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  remaining_q, remaining_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic                   done_q, done_d;
    logic [IDX_W:0]         tz_count;
    logic [DATA_WIDTH-1:0]  remaining_clr;
    logic                   is_last;

    trailing_zeros #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tz (
        .din  (remaining_q),
        .dout (tz_count)
    );

    // Lowest-set-bit clear and single-bit detection on the remaining mask.
    always_comb begin
        remaining_clr = remaining_q & (remaining_q - DATA_WIDTH'(1));
        is_last       = (remaining_clr == {DATA_WIDTH{1'b0}});
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == SCAN);
        out_idx   = tz_count[IDX_W-1:0];
        out_last  = is_last;
        out_seq   = seq_q;
        done      = done_q;
    end

    // Next-state logic for the scheduler FSM and its datapath.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        seq_d       = seq_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    remaining_d = in_mask;
                    seq_d       = {SEQ_W{1'b0}};
                    if (in_mask != {DATA_WIDTH{1'b0}}) begin
                        state_d = SCAN;
                    end else begin
                        // Empty mask completes immediately without a beat.
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (tz_count[IDX_W]) begin
                    // Empty mask in SCAN cannot occur normally; recover
                    // silently rather than present the all-zero code.
                    state_d = IDLE;
                end else if (out_ready) begin
                    remaining_d = remaining_clr;
                    seq_d       = seq_q + SEQ_W'(1);
                    if (is_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SCAN;
                    end
                end else begin
                    state_d = SCAN;
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = {DATA_WIDTH{1'b0}};
                seq_d       = {SEQ_W{1'b0}};
            end
        endcase
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= {DATA_WIDTH{1'b0}};
            seq_q       <= {SEQ_W{1'b0}};
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            seq_q       <= seq_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_bit_scan_scheduler.sv
module tb_bit_scan_scheduler;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_mask;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic [3:0] out_seq;
    logic       done;

    int total;
    int bad;

    bit_scan_scheduler #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_seq   (out_seq),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The all-zero trailing-zero code must never be visible in SCAN.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            assert (dut.tz_count != 4'd8)
            else $error("FAIL tz_zero_code: tz_count=%0d in SCAN", dut.tz_count);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_mask = 8'h00; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (out_seq !== 4'd0) begin bad++; $display("FAIL reset_out_seq got=%0d exp=0", out_seq); end
    endtask

    task automatic test_multi_bit();
        logic [2:0] exp_idx [3];
        exp_idx[0] = 3'd2; exp_idx[1] = 3'd5; exp_idx[2] = 3'd7;
        in_valid = 1'b1; in_mask = 8'b1010_0100; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL a4_valid beat=%0d got=%b exp=1", k, out_valid); end
            total++; if (out_idx !== exp_idx[k]) begin bad++; $display("FAIL a4_idx beat=%0d got=%0d exp=%0d", k, out_idx, exp_idx[k]); end
            total++; if (out_seq !== 4'(k)) begin bad++; $display("FAIL a4_seq beat=%0d got=%0d exp=%0d", k, out_seq, k); end
            total++; if (out_last !== (k == 2)) begin bad++; $display("FAIL a4_last beat=%0d got=%b exp=%b", k, out_last, (k == 2)); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL a4_early_done beat=%0d got=%b exp=0", k, done); end
            tick();
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL a4_done got=%b exp=1", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL a4_idle_valid got=%b exp=0", out_valid); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL a4_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_zero_mask();
        in_valid = 1'b1; in_mask = 8'h00; out_ready = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL zero_ready_pre got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid got=%b exp=0", out_valid); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", done); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b exp=1", in_ready); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid_after got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL zero_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_mask = 8'h80; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", k, out_valid); end
            total++; if (out_idx !== 3'd7) begin bad++; $display("FAIL stall_idx cyc=%0d got=%0d exp=7", k, out_idx); end
            total++; if (out_last !== 1'b1) begin bad++; $display("FAIL stall_last cyc=%0d got=%b exp=1", k, out_last); end
            total++; if (out_seq !== 4'd0) begin bad++; $display("FAIL stall_seq cyc=%0d got=%0d exp=0", k, out_seq); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
            if (k == 2) out_ready = 1'b1;
            tick();
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", done); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_after got=%b exp=1", in_ready); end
        tick();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_mask = 8'hFF; out_ready = 1'b1;
        tick();
        // Held valid with a different mask; must be ignored during SCAN.
        in_mask = 8'h06;
        for (int k = 0; k < 8; k++) begin
            total++; if (out_idx !== 3'(k)) begin bad++; $display("FAIL ff_idx beat=%0d got=%0d exp=%0d", k, out_idx, k); end
            total++; if (out_seq !== 4'(k)) begin bad++; $display("FAIL ff_seq beat=%0d got=%0d exp=%0d", k, out_seq, k); end
            total++; if (out_last !== (k == 7)) begin bad++; $display("FAIL ff_last beat=%0d got=%b exp=%b", k, out_last, (k == 7)); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ff_in_ready beat=%0d got=%b exp=0", k, in_ready); end
            tick();
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ff_done got=%b exp=1", done); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ff_done_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
        total++; if (out_idx !== 3'd1) begin bad++; $display("FAIL b2b_idx0 got=%0d exp=1", out_idx); end
        total++; if (out_seq !== 4'd0) begin bad++; $display("FAIL b2b_seq0 got=%0d exp=0", out_seq); end
        tick();
        total++; if (out_idx !== 3'd2) begin bad++; $display("FAIL b2b_idx1 got=%0d exp=2", out_idx); end
        total++; if (out_last !== 1'b1) begin bad++; $display("FAIL b2b_last got=%b exp=1", out_last); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done); end
        tick();
    endtask

    task automatic test_reset_mid_scan();
        in_valid = 1'b1; in_mask = 8'h0F; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_idx !== 3'd0) begin bad++; $display("FAIL rst_mid_idx0 got=%0d exp=0", out_idx); end
        tick();
        total++; if (out_idx !== 3'd1) begin bad++; $display("FAIL rst_mid_idx1 got=%0d exp=1", out_idx); end
        tick();
        total++; if (out_seq !== 4'd2) begin bad++; $display("FAIL rst_mid_seq2 got=%0d exp=2", out_seq); end
        // Reset coincides with a live handshake; reset must win.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
        total++; if (out_seq !== 4'd0) begin bad++; $display("FAIL rst_mid_seq got=%0d exp=0", out_seq); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b exp=0", done); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done_late cyc=%0d got=%b exp=0", k, done); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid_late cyc=%0d got=%b exp=0", k, out_valid); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1; in_valid = 1'b0; in_mask = 8'h00; out_ready = 1'b0;
        test_reset();
        test_multi_bit();
        test_zero_mask();
        test_stall();
        test_back_to_back();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
